// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 responder with byte-bus handshake, oversampled in the clk domain.
// Optional build macro: SPI_SLAVE_MISO_TRISTATE_EN (miso released to z when idle or in reset).
module spi_slave #(
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] bus_in,
  input  logic       cmd_write,
  output logic       busy_write,
  output logic [7:0] bus_out,
  output logic       data_avail,
  input  logic       cmd_read,
  output logic       overrun
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // [0] first sync stage, [1] synced value, [2] delayed copy for edge detection
  logic [2:0] sclk_sync_q, cs_sync_q;
  logic [1:0] mosi_sync_q;

  state_t     state_q, state_d;
  logic       warm_q, warm_d;
  logic       armed_q, armed_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       rx_done_q, rx_done_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] hold_q, hold_d;
  logic       busy_q, busy_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       avail_q, avail_d;
  logic       ovr_q, ovr_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, load;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      state_q     <= IDLE;
      warm_q      <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= 3'd0;
      rx_sh_q     <= 8'h00;
      rx_done_q   <= 1'b0;
      tx_sh_q     <= 8'h00;
      hold_q      <= 8'h00;
      busy_q      <= 1'b0;
      bus_out_q   <= 8'h00;
      avail_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      cs_sync_q   <= {cs_sync_q[1:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      state_q     <= state_d;
      warm_q      <= warm_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      rx_done_q   <= rx_done_d;
      tx_sh_q     <= tx_sh_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      bus_out_q   <= bus_out_d;
      avail_q     <= avail_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    warm_d    = 1'b1;
    // A frame already in progress when reset drops must not look like a new
    // cs_n fall: only arm once the real pin level has been seen high.
    armed_d   = armed_q | (warm_q & cs_sync_q[0] & cs_sync_q[1]);
    cnt_d     = cnt_q;
    rx_sh_d   = rx_sh_q;
    rx_done_d = 1'b0;
    tx_sh_d   = tx_sh_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    bus_out_d = bus_out_q;
    avail_d   = avail_q;
    ovr_d     = ovr_q;
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (cs_fall && armed_q) begin
          state_d = ACTIVE;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (sclk_rise) begin
            rx_sh_d   = {rx_sh_q[6:0], mosi_sync_q[1]};
            cnt_d     = cnt_q + 3'd1;
            rx_done_d = (cnt_q == 3'd7);
          end
          if (sclk_fall) begin
            if (cnt_q == 3'd0) load = 1'b1;
            else tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Load sees the pre-write holding state; a same-cycle write queues for the next byte.
    if (load) begin
      tx_sh_d = busy_q ? hold_q : FILL_BYTE;
      busy_d  = 1'b0;
    end
    if (cmd_write && !busy_q) begin
      hold_d = bus_in;
      busy_d = 1'b1;
    end

    if (cmd_read) begin
      avail_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (rx_done_q) begin
      bus_out_d = rx_sh_q;
      avail_d   = 1'b1;
      if (avail_q && !cmd_read) ovr_d = 1'b1;
    end
  end

  assign busy_write = busy_q;
  assign bus_out    = bus_out_q;
  assign data_avail = avail_q;
  assign overrun    = ovr_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = (state_q == ACTIVE && !reset) ? tx_sh_q[7] : 1'bz;
`else
  assign miso = (state_q == ACTIVE && !reset) ? tx_sh_q[7] : 1'b1;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed bench for spi_slave acting as an SPI master at sclk = clk/8.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       reset, sclk, cs_n, mosi, miso;
  logic [7:0] bus_in, bus_out;
  logic       cmd_write, busy_write, data_avail, cmd_read, overrun;

  int total = 0;
  int bad   = 0;

  logic [7:0] rx0, rx1;
  logic       da3, da4, busy_ld;
  logic       idle_lvl;

  spi_slave #(.FILL_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .bus_in(bus_in), .cmd_write(cmd_write), .busy_write(busy_write),
    .bus_out(bus_out), .data_avail(data_avail), .cmd_read(cmd_read), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cs_lo();
    cs_n = 1'b0;
    wait_clks(6);
    busy_ld = busy_write;
  endtask

  task automatic cs_hi();
    wait_clks(4);
    cs_n = 1'b1;
    wait_clks(6);
  endtask

  // Clocks out the top n bits of tx; returns what the master sampled on miso.
  task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      wait_clks(4);
      sclk = 1'b1;
      rx[i] = miso;
      wait_clks(3);
      da3 = data_avail;
      wait_clks(1);
      da4 = data_avail;
      sclk = 1'b0;
    end
  endtask

  task automatic pulse_read();
    cmd_read = 1'b1;
    wait_clks(1);
    cmd_read = 1'b0;
    wait_clks(1);
  endtask

  task automatic pulse_write(input logic [7:0] b);
    bus_in    = b;
    cmd_write = 1'b1;
    wait_clks(1);
    cmd_write = 1'b0;
    wait_clks(1);
  endtask

  initial begin
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    idle_lvl = 1'bz;
`else
    idle_lvl = 1'b1;
`endif
    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    bus_in = 8'h00; cmd_write = 1'b0; cmd_read = 1'b0;
    wait_clks(3);
    chk("miso_in_reset", {7'd0, miso}, {7'd0, idle_lvl});
    reset = 1'b0;
    wait_clks(3);
    chk("rst_bus_out", bus_out, 8'h00);
    chk("rst_data_avail", {7'd0, data_avail}, 8'h00);
    chk("rst_busy_write", {7'd0, busy_write}, 8'h00);
    chk("rst_overrun", {7'd0, overrun}, 8'h00);
    chk("miso_idle", {7'd0, miso}, {7'd0, idle_lvl});

    // Receive 0xA5, no byte queued
    cs_lo();
    xfer_bits(8'hA5, 8, rx0);
    chk("a5_da_at3", {7'd0, da3}, 8'h00);
    chk("a5_da_at4", {7'd0, da4}, 8'h01);
    chk("a5_bus_out", bus_out, 8'hA5);
    chk("a5_master_rx", rx0, 8'hFF);
    cs_hi();
    chk("miso_idle_after", {7'd0, miso}, {7'd0, idle_lvl});
    pulse_read();
    chk("a5_read_clears", {7'd0, data_avail}, 8'h00);

    // Queued 0x3C is loaded at the cs_n fall
    pulse_write(8'h3C);
    chk("q3c_busy_set", {7'd0, busy_write}, 8'h01);
    cs_lo();
    chk("q3c_busy_clr", {7'd0, busy_ld}, 8'h00);
    xfer_bits(8'h5A, 8, rx0);
    chk("q3c_master_rx", rx0, 8'h3C);
    chk("q3c_bus_out", bus_out, 8'h5A);
    cs_hi();
    pulse_read();

    // Two bytes without read: fill bytes out, overrun in
    cs_lo();
    xfer_bits(8'h11, 8, rx0);
    chk("ov_first_da", {7'd0, data_avail}, 8'h01);
    chk("ov_first_ovr", {7'd0, overrun}, 8'h00);
    xfer_bits(8'h22, 8, rx1);
    cs_hi();
    chk("fill_rx0", rx0, 8'hFF);
    chk("fill_rx1", rx1, 8'hFF);
    chk("ov_bus_out", bus_out, 8'h22);
    chk("ov_set", {7'd0, overrun}, 8'h01);
    pulse_read();
    chk("ov_read_da", {7'd0, data_avail}, 8'h00);
    chk("ov_read_ovr", {7'd0, overrun}, 8'h00);

    // Aborted partial byte, then 0x81
    cs_lo();
    xfer_bits(8'hF0, 4, rx0);
    cs_hi();
    chk("part_da", {7'd0, data_avail}, 8'h00);
    chk("part_bus_out", bus_out, 8'h22);
    cs_lo();
    xfer_bits(8'h81, 8, rx0);
    cs_hi();
    chk("x81_bus_out", bus_out, 8'h81);
    chk("x81_da", {7'd0, data_avail}, 8'h01);
    chk("x81_ovr", {7'd0, overrun}, 8'h00);
    pulse_read();

    // Write while busy is ignored
    pulse_write(8'h3C);
    pulse_write(8'h77);
    cs_lo();
    xfer_bits(8'h00, 8, rx0);
    pulse_read();
    xfer_bits(8'hC3, 8, rx1);
    cs_hi();
    chk("wbusy_rx0", rx0, 8'h3C);
    chk("wbusy_rx1", rx1, 8'hFF);
    chk("wbusy_bus_out", bus_out, 8'hC3);
    pulse_read();

    // Reset mid-frame: rest of frame ignored until a fresh cs_n fall
    pulse_write(8'h99);
    cs_lo();
    xfer_bits(8'hE0, 3, rx0);
    reset = 1'b1;
    wait_clks(2);
    chk("midrst_miso", {7'd0, miso}, {7'd0, idle_lvl});
    reset = 1'b0;
    wait_clks(2);
    chk("midrst_busy", {7'd0, busy_write}, 8'h00);
    xfer_bits(8'hFF, 5, rx0);
    xfer_bits(8'hAA, 8, rx0);
    chk("midrst_da", {7'd0, data_avail}, 8'h00);
    chk("midrst_bus_out", bus_out, 8'h00);
    chk("midrst_miso_lowcs", {7'd0, miso}, {7'd0, idle_lvl});
    cs_hi();
    cs_lo();
    xfer_bits(8'h42, 8, rx0);
    cs_hi();
    chk("post_rst_bus_out", bus_out, 8'h42);
    chk("post_rst_da", {7'd0, data_avail}, 8'h01);
    chk("post_rst_rx", rx0, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 responder that lets an external SPI master (another MKR board, or the SAM-side SPI) exchange bytes with FPGA logic. The block oversamples `sclk`, `cs_n` and `mosi` in the 48 MHz system clock domain, deserialises received bytes onto `bus_out`, and serialises bytes from `bus_in` onto `miso`. Its byte-bus handshake (`cmd_read`, `cmd_write`, `data_avail`, `busy_write`) matches the existing `uart`/`spi` blocks, so it can be chained with them in the top level.

## Interface
- `FILL_BYTE`, default 8'hFF: byte shifted out when no transmit byte is queued.
- `clk` input 1: system clock (48 MHz); the only clock.
- `reset` input 1: synchronous, active-high reset.
- `sclk` input 1: SPI clock from master, asynchronous to `clk`.
- `cs_n` input 1: chip select, active low, asynchronous.
- `mosi` input 1: master-out data, asynchronous.
- `miso` output 1: slave-out data.
- `bus_in` input 8: transmit byte, captured on an accepted `cmd_write`.
- `cmd_write` input 1: one-cycle request to queue `bus_in`; ignored while `busy_write`=1.
- `busy_write` output 1: transmit holding register full.
- `bus_out` output 8: last complete received byte.
- `data_avail` output 1: `bus_out` holds an unread byte.
- `cmd_read` input 1: one-cycle acknowledge; clears `data_avail` and `overrun`.
- `overrun` output 1: sticky; a byte completed while `data_avail` was still 1.

## Operation
- Synchroniser: two flip-flops each on `sclk`, `cs_n` and `mosi`. Edge detection uses a third registered copy of `sclk` and `cs_n`.
- States:
  - IDLE: synced `cs_n`=1. Bit counter held at 0.
  - ACTIVE: synced `cs_n`=0.
  - IDLE→ACTIVE on the synced `cs_n` falling edge. ACTIVE→IDLE on the synced `cs_n` rising edge.
- Receive: on each synced `sclk` rising edge in ACTIVE, shift the synced `mosi` into the RX shift register, MSB first, and increment the 3-bit counter (wraps 7→0).
  - When the 8th bit arrives, the next cycle loads `bus_out`, sets `data_avail`=1, and sets `overrun`=1 if `data_avail` was already 1.
- Transmit: `miso` = TX shift register bit 7 while ACTIVE.
  - Load TX shift register on the `cs_n` falling edge, and on a synced `sclk` falling edge when the counter is 0.
  - On a synced `sclk` falling edge with the counter ≠ 0, shift left.
  - A load takes the holding register if `busy_write`=1 and clears `busy_write`; otherwise it takes `FILL_BYTE`.
- `cmd_write` with `busy_write`=0 captures `bus_in` and sets `busy_write`=1 on the next cycle.
- Simultaneous events:
  - `cmd_write` in the same cycle as a load: the load uses the pre-write holding state. The written byte stays queued for the following byte.
  - Byte completion in the same cycle as `cmd_read`: `data_avail` stays 1, `bus_out` takes the new byte, and `overrun` is unchanged by the completion.
  - `cmd_read` with `data_avail`=0: no effect beyond clearing `overrun`.
- `cs_n` rising mid-byte: counter reset to 0 and the partial RX byte discarded. `data_avail` and `bus_out` are unchanged. A TX byte already loaded is lost and is not re-queued.
- Reset mid-transfer: all state cleared. The remainder of the current frame is ignored until the next `cs_n` falling edge.

## Timing
- Reset values:
  - `bus_out`=8'h00, `data_avail`=0, `busy_write`=0, `overrun`=0.
  - `miso` at idle level.
  - Counter=0, state IDLE, synchronisers =1 for `cs_n`/`sclk` idle high… except `sclk` synchroniser, which resets to 0.
- Input latency: pin to detected edge is 3 `clk` cycles.
- RX latency: `data_avail` rises 4 `clk` cycles after the 8th `sclk` rising edge at the pin.
- TX: `miso` changes 3–4 cycles after the `sclk` falling edge or `cs_n` falling edge at the pin.
- Master constraints:
  - `sclk` high and low phases ≥ 4 `clk` each, so `sclk` ≤ 6 MHz.
  - ≥ 5 `clk` from `cs_n` fall to the first `sclk` rise.
  - ≥ 4 `clk` from the last `sclk` fall to `cs_n` rise.
- `busy_write` clears on the cycle after the load edge is detected.

## Configuration
- `SPI_SLAVE_MISO_TRISTATE_EN` defined: `miso` = 1'bz in IDLE and during reset, so several slaves can share the line.
- Not defined: `miso` driven 1 in IDLE and during reset.
- Behaviour in ACTIVE is identical in both builds.

## Test plan
- Master sends 0xA5 (sclk = clk/8): `bus_out`=0xA5, `data_avail`=1 within 4 cycles of the 8th rise. `cmd_read` pulse → `data_avail`=0.
- Queue 0x3C via `cmd_write`, then master clocks one byte: master reads 0x3C, `busy_write` 1→0 at the `cs_n` fall load.
- No byte queued, master clocks two bytes: master reads 0xFF, 0xFF (`FILL_BYTE`).
- Master sends 0x11 then 0x22 without `cmd_read`: `bus_out`=0x22, `overrun`=1. `cmd_read` clears both flags.
- `cs_n` raised after 4 bits, then a new frame with 0x81: `bus_out`=0x81 and `data_avail` set once; the partial byte is never presented.
- Tristate build: `miso`=z while `cs_n`=1 and during reset. Non-tristate build: `miso`=1 in the same conditions.
